// File: rtl/mcp4922_rx.sv
// MCP4922 SPI frame receiver: synchronises the serial pins, decodes 16-bit
// frames and models the per-channel input latches and LDAC-driven DAC registers.
module mcp4922_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_pin,
    input  logic        clk_pin,
    input  logic        data_pin,
    input  logic        ldac_n,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [2:0]  cfg_a,
    output logic [2:0]  cfg_b,
    output logic        frame_valid,
    output logic        frame_axis,
    output logic        frame_err
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_MAX    = 17;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned VAL_W      = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] ldac_sync;
    logic                   cs_prev;
    logic                   sclk_prev;
    logic                   ldac_prev;

    logic cs_s;
    logic sclk_s;
    logic data_s;
    logic ldac_s;
    logic cs_rise;
    logic cs_fall;
    logic sclk_rise;
    logic ldac_fall;

    state_t             state;
    logic [15:0]        shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               frame_done;
    logic               accept;
    logic [VAL_W-1:0]   latch_a;
    logic [VAL_W-1:0]   latch_b;
    logic [VAL_W-1:0]   latch_a_nxt;
    logic [VAL_W-1:0]   latch_b_nxt;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign ldac_s    = ldac_sync[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ldac_fall = ~ldac_s & ldac_prev;

    // cs rising inside a frame closes it; only exactly 16 counted bits are accepted
    assign frame_done = (state == SHIFT) && cs_rise;
    assign accept     = frame_done && (bit_cnt == CNT_W'(FRAME_BITS));

    // Pin synchronisers plus previous-value registers for edge detection; idle on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            data_sync <= '0;
            ldac_sync <= '1;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            ldac_prev <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], clk_pin};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_pin};
            ldac_sync <= {ldac_sync[SYNC_STAGES-2:0], ldac_n};
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
            ldac_prev <= ldac_s;
        end
    end

    // Frame FSM: wait for cs fall, then shift on sclk rise until cs rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[14:0], data_s};
                        if (bit_cnt != CNT_W'(CNT_MAX)) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next input-latch contents, so a same-cycle LDAC transfer sees the new frame
    always_comb begin
        latch_a_nxt = latch_a;
        latch_b_nxt = latch_b;
        if (accept) begin
            if (shift_reg[15]) begin
                latch_b_nxt = shift_reg[11:0];
            end else begin
                latch_a_nxt = shift_reg[11:0];
            end
        end
    end

    // Latches, config, DAC registers and frame status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_a     <= '0;
            latch_b     <= '0;
            dac_a       <= '0;
            dac_b       <= '0;
            cfg_a       <= '0;
            cfg_b       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_axis  <= 1'b0;
        end else begin
            frame_valid <= accept;
            frame_err   <= frame_done && !accept;
            latch_a     <= latch_a_nxt;
            latch_b     <= latch_b_nxt;
            if (accept) begin
                frame_axis <= shift_reg[15];
                if (shift_reg[15]) begin
                    cfg_b <= shift_reg[14:12];
                end else begin
                    cfg_a <= shift_reg[14:12];
                end
            end
            if (ldac_fall) begin
                dac_a <= latch_a_nxt;
                dac_b <= latch_b_nxt;
            end else if (!ldac_s && accept) begin
                if (shift_reg[15]) begin
                    dac_b <= latch_b_nxt;
                end else begin
                    dac_a <= latch_a_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcp4922_rx.sv
// Bench for mcp4922_rx: serial transmitter, frame-level reference model and
// scoreboard monitor; a second instance with three sync stages shares the pins.
module tb_mcp4922_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_pin, clk_pin, data_pin, ldac_n;
    logic [11:0] dac_a, dac_b, dac_a3, dac_b3;
    logic [2:0]  cfg_a, cfg_b, cfg_a3, cfg_b3;
    logic        frame_valid, frame_axis, frame_err;
    logic        frame_valid3, frame_axis3, frame_err3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cs_hi_cyc = 0;
    int v2_cyc = -1;
    int v3_cyc = -1;

    typedef struct {
        logic        is_err;
        logic        axis;
        logic [11:0] da;
        logic [11:0] db;
        logic [2:0]  ca;
        logic [2:0]  cb;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: device-visible state after each frame
    logic [11:0] m_latch[2];
    logic [11:0] m_dac[2];
    logic [2:0]  m_cfg[2];
    logic        m_axis;

    mcp4922_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cs_pin(cs_pin), .clk_pin(clk_pin),
        .data_pin(data_pin), .ldac_n(ldac_n), .dac_a(dac_a), .dac_b(dac_b),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .frame_valid(frame_valid),
        .frame_axis(frame_axis), .frame_err(frame_err)
    );

    mcp4922_rx #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .cs_pin(cs_pin), .clk_pin(clk_pin),
        .data_pin(data_pin), .ldac_n(ldac_n), .dac_a(dac_a3), .dac_b(dac_b3),
        .cfg_a(cfg_a3), .cfg_b(cfg_b3), .frame_valid(frame_valid3),
        .frame_axis(frame_axis3), .frame_err(frame_err3)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of each frame_valid for both instances
    always @(negedge clk) begin
        if (frame_valid)  v2_cyc = cyc;
        if (frame_valid3) v3_cyc = cyc;
    end

    // Scoreboard monitor: every status pulse must match the next expected event
    always @(negedge clk) begin
        if (frame_valid || frame_err) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b with nothing expected",
                         frame_valid, frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_err !== e.is_err || frame_valid !== !e.is_err ||
                    (!e.is_err && frame_axis !== e.axis) ||
                    dac_a !== e.da || dac_b !== e.db || cfg_a !== e.ca || cfg_b !== e.cb) begin
                    bad++;
                    $display("FAIL frame_check: got valid=%0b err=%0b axis=%0b a=%h b=%h ca=%b cb=%b want err=%0b axis=%0b a=%h b=%h ca=%b cb=%b",
                             frame_valid, frame_err, frame_axis, dac_a, dac_b, cfg_a, cfg_b,
                             e.is_err, e.axis, e.da, e.db, e.ca, e.cb);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_latch[i] = '0;
            m_dac[i]   = '0;
            m_cfg[i]   = '0;
        end
        m_axis = 1'b0;
    endtask

    // Drive nbits sclk pulses, MSB first; bits beyond 16 are random
    task automatic shift_bits(input int nbits, input logic [15:0] word);
        for (int i = 0; i < nbits; i++) begin
            data_pin = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
            clk_pin  = 1'b0;
            tick(2);
            clk_pin  = 1'b1;
            tick(2);
        end
        clk_pin = 1'b0;
        tick(2);
    endtask

    // Full transaction: model the frame, push the expectation, then close with cs
    task automatic send_frame(input int nbits, input logic [15:0] word);
        exp_t e;
        int   ch;
        cs_pin = 1'b0;
        tick(2);
        shift_bits(nbits, word);
        if (nbits == 16) begin
            ch = int'(word[15]);
            m_cfg[ch]   = word[14:12];
            m_latch[ch] = word[11:0];
            m_axis      = word[15];
            if (ldac_n == 1'b0) m_dac[ch] = m_latch[ch];
        end
        e.is_err = (nbits != 16);
        e.axis   = m_axis;
        e.da     = m_dac[0];
        e.db     = m_dac[1];
        e.ca     = m_cfg[0];
        e.cb     = m_cfg[1];
        exp_q.push_back(e);
        cs_hi_cyc = cyc;
        cs_pin = 1'b1;
        tick(8);
    endtask

    // LDAC falling edge copies both input latches to the outputs
    task automatic ldac_fall();
        ldac_n = 1'b0;
        tick(6);
        m_dac[0] = m_latch[0];
        m_dac[1] = m_latch[1];
        chk("ldac_dac_a", 16'(dac_a), 16'(m_dac[0]));
        chk("ldac_dac_b", 16'(dac_b), 16'(m_dac[1]));
    endtask

    // Watchdog so the run always ends
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   r;
        int   nb;

        reset_n = 1'b0;
        cs_pin = 1'b1; clk_pin = 1'b0; data_pin = 1'b0; ldac_n = 1'b1;
        model_reset();

        // Reset with random pin activity
        for (int i = 0; i < 20; i++) begin
            cs_pin   = 1'($urandom_range(0, 1));
            clk_pin  = 1'($urandom_range(0, 1));
            data_pin = 1'($urandom_range(0, 1));
            ldac_n   = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk("rst_dac_a", 16'(dac_a), 16'h0);
        chk("rst_dac_b", 16'(dac_b), 16'h0);
        chk("rst_cfg", {10'h0, cfg_a, cfg_b}, 16'h0);
        cs_pin = 1'b1; clk_pin = 1'b0; data_pin = 1'b0; ldac_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        chk("post_rst_dac", {2'b0, dac_a[6:0], dac_b[6:0]} | 16'(dac_a) | 16'(dac_b), 16'h0);
        chk("post_rst_cfg", {10'h0, cfg_a, cfg_b}, 16'h0);

        // Transparent loopback
        ldac_fall();
        send_frame(16, {1'b0, 3'b111, 12'h5A3});
        send_frame(16, {1'b1, 3'b111, 12'hFFF});

        // Short, long and empty frames
        send_frame(15, {1'b0, 3'b010, 12'h111});
        send_frame(17, {1'b1, 3'b001, 12'h222});
        send_frame(0,  16'h0);

        // Double buffering: writes land in latches only until LDAC falls
        ldac_n = 1'b1;
        tick(6);
        send_frame(16, {1'b0, 3'b110, 12'h123});
        send_frame(16, {1'b1, 3'b101, 12'h456});
        ldac_n = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (dac_a !== m_dac[0] || dac_b !== m_dac[1]) found = 1'b1;
        end
        total++;
        if (!found || dac_a !== 12'h123 || dac_b !== 12'h456) begin
            bad++;
            $display("FAIL ldac_same_cycle: got a=%h b=%h changed=%0b want a=123 b=456",
                     dac_a, dac_b, found);
        end
        m_dac[0] = m_latch[0];
        m_dac[1] = m_latch[1];
        tick(4);

        // Reset in the middle of a frame
        cs_pin = 1'b0;
        tick(2);
        shift_bits(8, 16'hA5C3);
        reset_n = 1'b0;
        cs_pin = 1'b1; clk_pin = 1'b0; data_pin = 1'b0; ldac_n = 1'b0;
        model_reset();
        tick(4);
        reset_n = 1'b1;
        tick(6);
        send_frame(16, {1'b0, 3'b011, 12'h00F});
        chk("midrst_dac_a", 16'(dac_a), 16'h00F);

        // Randomised frames with occasional LDAC level changes
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (ldac_n) ldac_fall();
                else begin
                    ldac_n = 1'b1;
                    tick(6);
                end
            end
            r  = int'($urandom_range(0, 9));
            nb = (r < 7) ? 16 : (r == 7) ? 15 : (r == 8) ? 17 : 0;
            send_frame(nb, 16'($urandom));
        end

        // Latency from first cs-high sampling edge to frame_valid
        send_frame(16, {1'b1, 3'b100, 12'h3C3});
        chk("latency_sync2", 16'(v2_cyc - cs_hi_cyc), 16'd3);
        chk("latency_sync3", 16'(v3_cyc - cs_hi_cyc), 16'd4);

        tick(20);
        chk("pending_expect", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
